// File: rtl/serial_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx_pkg
// Description : Shared state encoding and line-level constants for the
//               serial frame transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_frame_tx_pkg;

  // Frame phases; the encoding is fixed so state values are stable in debug
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Level the serial line rests at between frames (also the stop-bit level)
  localparam logic LINE_IDLE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_frame_tx_tick.sv
`default_nettype none
// ============================================================================
// Module      : bit_tick_counter
// Description : Counts clocks within one serial bit period and pulses
//               o_tick_done on the last clock of the period.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_tick_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick_done
);

  // One extra bit so the terminal value never wraps, even for powers of two
  localparam int                c_TICK_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(CLKS_PER_BIT - 1);

  logic [c_TICK_W-1:0] r_tick;

  // With CLKS_PER_BIT=1 the counter sits at zero and the pulse is constant
  assign o_tick_done = (r_tick == c_TICK_LAST);

  // Tick counter: held at zero while cleared, wraps at the end of each bit
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_tick <= '0;
    end else if (o_tick_done) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + c_TICK_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx
// Description : Valid/ready fed serializer. Emits start bit, DATA_W data bits
//               LSB first and a stop bit, each held CLKS_PER_BIT clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int                 c_CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(DATA_W - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic [c_CNT_W-1:0]  r_bit_cnt;
  logic [c_CNT_W-1:0]  w_bit_cnt_nxt;
  logic                r_tx_out;
  logic                w_tx_out_nxt;
  logic                w_accept;
  logic                w_tick_clear;
  logic                w_tick_done;

  // Ready and busy are pure state decode; the line itself is registered
  assign tx_ready     = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign tx_out       = r_tx_out;
  assign w_accept     = tx_valid && (r_state == IDLE);
  // Keeping the counter cleared in IDLE makes every START begin at tick 0
  assign w_tick_clear = (r_state == IDLE);

  bit_tick_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tick (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_tick_clear),
    .o_tick_done (w_tick_done)
  );

  // Next-state, shift/count update and next line level (decoded from next state)
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_out_nxt  = LINE_IDLE;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt   = START;
          w_shift_nxt   = tx_data;
          w_bit_cnt_nxt = '0;
        end
      end
      START: begin
        if (w_tick_done) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_tick_done) begin
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = r_bit_cnt + c_CNT_W'(1);
          if (r_bit_cnt == c_BIT_LAST) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (w_tick_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Registering the level of the state being entered puts the start bit
    // on the line in the first cycle after acceptance
    case (w_state_nxt)
      START:   w_tx_out_nxt = 1'b0;
      DATA:    w_tx_out_nxt = w_shift_nxt[0];
      default: w_tx_out_nxt = LINE_IDLE;
    endcase
  end

  // State, datapath and line register; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx_out  <= LINE_IDLE;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx_out  <= w_tx_out_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_tx
// Description : Self-checking bench for serial_frame_tx. One instance with
//               4 clocks per bit, one with 1 clock per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

  localparam int DW    = 8;
  localparam int CPB_A = 4;
  localparam int CPB_B = 1;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       e_out;
    logic       e_rdy;
    logic       e_bsy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       va, vb;
  logic [7:0] da, db;
  logic       a_out, a_rdy, a_bsy;
  logic       b_out, b_rdy, b_bsy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a frame is a start offset and a word; line level follows
  // from which bit slot the offset falls into
  logic       m_act [2];
  int         m_off [2];
  logic [7:0] m_dat [2];

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB_A)) u_dut_a (
    .clk(clk), .reset(reset), .tx_data(da), .tx_valid(va),
    .tx_ready(a_rdy), .tx_out(a_out), .busy(a_bsy)
  );

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB_B)) u_dut_b (
    .clk(clk), .reset(reset), .tx_data(db), .tx_valid(vb),
    .tx_ready(b_rdy), .tx_out(b_out), .busy(b_bsy)
  );

  function automatic int cpb(int i);
    return (i == 0) ? CPB_A : CPB_B;
  endfunction

  function automatic logic m_line(int i);
    int b;
    if (!m_act[i]) return 1'b1;
    b = m_off[i] / cpb(i);
    if (b == 0) return 1'b0;
    if (b <= DW) return m_dat[i][b-1];
    return 1'b1;
  endfunction

  task automatic m_edge(int i, logic rst, logic v, logic [7:0] d);
    if (rst) begin
      m_act[i] = 1'b0;
    end else if (m_act[i]) begin
      m_off[i] = m_off[i] + 1;
      if (m_off[i] == (DW + 2) * cpb(i)) m_act[i] = 1'b0;
    end else if (v) begin
      m_act[i] = 1'b1;
      m_off[i] = 0;
      m_dat[i] = d;
    end
  endtask

  task automatic chk(string nm, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_model(int i, string tag);
    logic o, r, b;
    o = (i == 0) ? a_out : b_out;
    r = (i == 0) ? a_rdy : b_rdy;
    b = (i == 0) ? a_bsy : b_bsy;
    chk($sformatf("%s.%0d.tx_out", tag, i), o, m_line(i));
    chk($sformatf("%s.%0d.tx_ready", tag, i), r, !m_act[i]);
    chk($sformatf("%s.%0d.busy", tag, i), b, m_act[i]);
  endtask

  // Apply inputs, take one rising edge, advance the model, settle at negedge
  task automatic cyc(logic rst, logic v0, logic [7:0] d0, logic v1, logic [7:0] d1);
    reset = rst; va = v0; da = d0; vb = v1; db = d1;
    @(posedge clk);
    m_edge(0, rst, v0, d0);
    m_edge(1, rst, v1, d1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[$];
    logic [9:0] fa;
    logic [9:0] fb;
    int         cnt;
    int         at;
    logic       r_rst, r_va, r_vb;

    reset = 1'b1; va = 1'b0; vb = 1'b0; da = '0; db = '0;
    m_act[0] = 1'b0; m_act[1] = 1'b0;
    m_off[0] = 0;    m_off[1] = 0;
    m_dat[0] = '0;   m_dat[1] = '0;

    // Reset, idle, then an 8'hA5 frame: start, 1,0,1,0,0,1,0,1, stop
    fa = 10'b1101001010;
    for (int k = 0; k < 2; k++) tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0});
    for (int k = 0; k < 3; k++) tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1});
    for (int k = 1; k < 40; k++) tbl.push_back('{1'b0, 1'b0, 8'h5A, fa[k/4], 1'b0, 1'b1});
    for (int k = 0; k < 2; k++) tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0});

    foreach (tbl[k]) begin
      cyc(tbl[k].rst, tbl[k].valid, tbl[k].data, 1'b0, 8'h00);
      chk($sformatf("tbl%0d.tx_out", k), a_out, tbl[k].e_out);
      chk($sformatf("tbl%0d.tx_ready", k), a_rdy, tbl[k].e_rdy);
      chk($sformatf("tbl%0d.busy", k), a_bsy, tbl[k].e_bsy);
      chk_model(1, "tbl_b");
    end

    // Continuous valid: 3C then FF, exactly one ready cycle between frames
    cnt = 0; at = -1;
    for (int k = 0; k < 81; k++) begin
      cyc(1'b0, 1'b1, (k == 0) ? 8'h3C : 8'hFF, 1'b0, 8'h00);
      chk_model(0, $sformatf("b2b%0d", k));
      if (a_rdy) begin cnt++; at = k; end
    end
    chk_int("b2b_ready_cycles", cnt, 1);
    chk_int("b2b_ready_position", at, 40);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk_model(0, "b2b_tail");
    end

    // Reset 15 cycles into an 8'h00 frame: line returns to idle for good
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    chk_model(0, "abort_acc");
    for (int k = 1; k < 15; k++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk_model(0, "abort_pre");
    end
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("abort_rst.tx_out", a_out, 1'b1);
    chk("abort_rst.tx_ready", a_rdy, 1'b1);
    chk("abort_rst.busy", a_bsy, 1'b0);
    cnt = 0;
    for (int k = 0; k < 45; k++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk_model(0, "abort_post");
      if (a_out !== 1'b1 || a_bsy !== 1'b0) cnt++;
    end
    chk_int("abort_no_leftover", cnt, 0);

    // Valid pulse with 8'h81 mid-frame must be dropped, not queued
    cnt = 0;
    cyc(1'b0, 1'b1, 8'hC3, 1'b0, 8'h00);
    if (a_bsy) cnt++;
    chk_model(0, "busy_acc");
    for (int k = 1; k < 60; k++) begin
      cyc(1'b0, (k == 10 || k == 11), 8'h81, 1'b0, 8'h00);
      chk_model(0, $sformatf("busy%0d", k));
      if (a_bsy) cnt++;
    end
    chk_int("busy_single_frame_len", cnt, 40);

    // One clock per bit: 8'h01 gives 0,1,0,0,0,0,0,0,0,1 then ready
    fb = 10'b1000000010;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 8'h00, (k == 0), 8'h01);
      chk($sformatf("cpb1_%0d.tx_out", k), b_out, fb[k]);
      chk($sformatf("cpb1_%0d.busy", k), b_bsy, 1'b1);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("cpb1_end.tx_ready", b_rdy, 1'b1);
    chk("cpb1_end.tx_out", b_out, 1'b1);

    // Random traffic on both instances against the model
    for (int k = 0; k < 800; k++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_va  = ($urandom_range(0, 3) == 0);
      r_vb  = ($urandom_range(0, 2) == 0);
      cyc(r_rst, r_va, 8'($urandom), r_vb, 8'($urandom));
      chk_model(0, $sformatf("rnd%0d", k));
      chk_model(1, $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
